uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares one uart_tx instance between N_REQ byte producers.
- Latches the winning requester's byte and frame configuration, then drives uart_tx's send/config inputs stable for the whole frame.
- Sequences one frame through the tx_active/tx_done handshake, acks the requester and rotates priority.
- Sits between the producers and uart_tx in the top level, in the 50 MHz clk domain.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- START_TO, 1024, max clk cycles from send to tx_active rising before abort.
- FRAME_TO, 65535, max clk cycles from tx_active rising to tx_done rising before abort.

Ports:
- clk  in  1  system clock, 50 MHz
- arst_n  in  1  reset, synchronous, active-low (name kept for codebase consistency)
- req  in  N_REQ  per-requester request level, held until ack
- req_data  in  8*N_REQ  byte for requester i in bits [8i+7:8i]
- req_cfg  in  6*N_REQ  per-requester frame config in bits [6i+5:6i]: {baud_rate[1:0], parity_type[1:0], stop_bits, data_length}
- grant  out  N_REQ  one-hot owner of the current frame, 0 when idle
- ack  out  N_REQ  1-cycle pulse on the owner's bit at frame completion
- err  out  1  1-cycle pulse with ack when the frame aborted on timeout
- busy  out  1  high from LOAD through DONE
- uart_send  out  1  to uart_tx.send
- uart_data  out  8  to uart_tx.data_in
- uart_baud_rate  out  2  to uart_tx.baud_rate
- uart_parity_type  out  2  to uart_tx.parity_type
- uart_stop_bits  out  1  to uart_tx.stop_bits
- uart_data_length  out  1  to uart_tx.data_length
- uart_tx_active  in  1  from uart_tx.tx_active (baud-domain derived, level)
- uart_tx_done  in  1  from uart_tx.tx_done

Behaviour:
- Reset (arst_n low at a clk edge):
  - state=IDLE, ptr=0, all outputs 0 (grant, ack, err, busy, uart_send, uart_data, all uart cfg outputs).
  - Reset mid-frame drops uart_send at once; uart_tx is on the same reset and is not resumed.
- Input synchronisation: uart_tx_active and uart_tx_done each pass through a 2-flop synchroniser, then a rising-edge detector on the synchronised value.
- FSM states:
  - IDLE:
    - If any req is set, select the first set bit scanning ptr, ptr+1, … mod N_REQ.
    - Latch its req_data and req_cfg into the uart_* outputs; set grant and busy; go to LOAD.
    - Arbitration takes 1 cycle: req seen in cycle t gives grant in cycle t+1.
  - LOAD: assert uart_send; clear the timer; go to START.
  - START:
    - Hold uart_send high until the synchronised tx_active rises, then drop uart_send, clear the timer and go to RUN.
    - If the timer reaches START_TO, drop uart_send and go to DONE with the abort flag set.
  - RUN:
    - On the rising edge of synchronised tx_done, go to DONE.
    - If the timer reaches FRAME_TO, go to DONE with the abort flag set.
    - A tx_done edge and timer expiry in the same cycle count as success.
  - DONE (1 cycle):
    - Pulse ack[owner]; pulse err if the abort flag is set.
    - Set ptr = (owner+1) mod N_REQ; clear grant, busy and the abort flag; go to IDLE.
- uart_data and uart_* cfg outputs change only in IDLE→LOAD; they are stable from LOAD through DONE. Changes on req_data/req_cfg during a frame are ignored.
- Minimum gap between frames: IDLE→LOAD is 2 cycles after DONE. A requester still asserting req after ack is eligible again, but behind every other pending requester.
- Requester drops req mid-frame: the frame still completes and ack is still pulsed.
- Simultaneous requests: strict round-robin, so no requester waits more than N_REQ−1 frames.
- Timer: 16-bit saturating; counts only in START and RUN.

Decomposition:
- Package uart_pkg:
  - cfg field widths and offsets (CFG_W=6).
  - FSM state encoding (IDLE, LOAD, START, RUN, DONE).
  - default START_TO/FRAME_TO.
- Sub-module rr_arbiter (N_REQ):
  - inputs: req, ptr, valid-enable.
  - outputs: one-hot grant, owner index.
  - purely combinational; ptr register stays in the parent.
- Edge-detect/synchroniser stays inline.

Test Plan:
- Single request: req[0]=1, data 0x55, cfg {baud 2'b01, parity 2'b01, stop 0, len 1} → grant=4'b0001 next cycle; uart_send high until tx_active; serial line shows 0x55 with odd parity; ack[0] pulses once; err=0.
- Contention: req=4'b1111 held, ptr=0 → grant order 0,1,2,3,0; each ack pulses exactly once per frame; uart_data matches each owner's byte.
- Late data change: change req_data[1] from 0xA3 to 0x3C during RUN → uart_data stays 0xA3 until DONE.
- Start timeout: uart_tx_active tied 0, START_TO=16 → uart_send drops after 16 timer cycles; ack and err pulse together; ptr advances.
- Reset mid-frame: arst_n low during RUN → next cycle all outputs 0, state IDLE; after release, a pending req[2] is granted first, since ptr=0 and req[0] and req[1] are idle.
- Request withdrawal: req[3] drops during START → frame completes and ack[3] still pulses; no second frame is issued.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types for the UART transmit arbiter slice.
// Frame config layout, FSM states and timeout defaults.
package uart_pkg;

  localparam int DATA_W       = 8;
  localparam int CFG_W        = 6;
  localparam int TMR_W        = 16;
  localparam int START_TO_DEF = 1024;
  localparam int FRAME_TO_DEF = 65535;

  // Field order matches {baud_rate, parity_type, stop_bits, data_length}
  typedef struct packed {
    logic [1:0] baud_rate;
    logic [1:0] parity_type;
    logic       stop_bits;
    logic       data_length;
  } uart_cfg_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    RUN,
    DONE
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick starting at ptr.
// Owner index and one-hot grant are valid only when found is high.
module rr_arbiter #(
  parameter int N_REQ = 4,
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  input  logic             en,
  output logic [N_REQ-1:0] gnt,
  output logic [PW-1:0]    owner,
  output logic             found
);

  int idx;

  always_comb begin
    gnt   = '0;
    owner = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        owner    = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of one uart_tx: latches a byte and config,
// runs the send/tx_active/tx_done handshake, then acks and rotates.
import uart_pkg::*;

module uart_tx_arbiter #(
  parameter int N_REQ    = 4,
  parameter int START_TO = START_TO_DEF,
  parameter int FRAME_TO = FRAME_TO_DEF,
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [DATA_W*N_REQ-1:0] req_data,
  input  logic [CFG_W*N_REQ-1:0] req_cfg,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       ack,
  output logic                   err,
  output logic                   busy,
  output logic                   uart_send,
  output logic [7:0]             uart_data,
  output logic [1:0]             uart_baud_rate,
  output logic [1:0]             uart_parity_type,
  output logic                   uart_stop_bits,
  output logic                   uart_data_length,
  input  logic                   uart_tx_active,
  input  logic                   uart_tx_done
);

  arb_state_t       state;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    owner_q;
  logic [TMR_W-1:0] timer;
  logic [2:0]       act_s;
  logic [2:0]       done_s;
  uart_cfg_t        cfg_q;

  logic [N_REQ-1:0] arb_gnt;
  logic [PW-1:0]    arb_owner;
  logic             arb_found;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req   (req),
    .ptr   (ptr),
    .en    (state == IDLE),
    .gnt   (arb_gnt),
    .owner (arb_owner),
    .found (arb_found)
  );

  logic             act_rise;
  logic             done_rise;
  logic [TMR_W:0]   timer_inc;
  logic [TMR_W-1:0] timer_sat;
  logic             start_hit;
  logic             frame_hit;
  logic [PW-1:0]    ptr_nxt;

  assign act_rise  = act_s[1] & ~act_s[2];
  assign done_rise = done_s[1] & ~done_s[2];
  assign timer_inc = {1'b0, timer} + 1'b1;
  assign timer_sat = timer_inc[TMR_W] ? '1 : timer_inc[TMR_W-1:0];
  // Expiry fires on the cycle the count reaches the limit
  assign start_hit = timer_inc >= (TMR_W+1)'(START_TO);
  assign frame_hit = timer_inc >= (TMR_W+1)'(FRAME_TO);
  assign ptr_nxt   = (int'(owner_q) == N_REQ - 1) ?
                     '0 : owner_q + 1'b1;

  assign uart_baud_rate   = cfg_q.baud_rate;
  assign uart_parity_type = cfg_q.parity_type;
  assign uart_stop_bits   = cfg_q.stop_bits;
  assign uart_data_length = cfg_q.data_length;

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      owner_q   <= '0;
      timer     <= '0;
      act_s     <= '0;
      done_s    <= '0;
      cfg_q     <= '0;
      grant     <= '0;
      ack       <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
      uart_send <= 1'b0;
      uart_data <= '0;
    end else begin
      act_s  <= {act_s[1:0], uart_tx_active};
      done_s <= {done_s[1:0], uart_tx_done};
      ack    <= '0;
      err    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (arb_found) begin
            grant     <= arb_gnt;
            owner_q   <= arb_owner;
            busy      <= 1'b1;
            uart_data <= req_data[int'(arb_owner)*DATA_W +: DATA_W];
            cfg_q     <= uart_cfg_t'(req_cfg[int'(arb_owner)*CFG_W +: CFG_W]);
            state     <= LOAD;
          end
        end
        LOAD: begin
          uart_send <= 1'b1;
          timer     <= '0;
          state     <= START;
        end
        START: begin
          if (act_rise) begin
            uart_send <= 1'b0;
            timer     <= '0;
            state     <= RUN;
          end else if (start_hit) begin
            uart_send <= 1'b0;
            ack       <= grant;
            err       <= 1'b1;
            state     <= DONE;
          end else begin
            timer <= timer_sat;
          end
        end
        RUN: begin
          if (done_rise) begin
            ack   <= grant;
            state <= DONE;
          end else if (frame_hit) begin
            ack   <= grant;
            err   <= 1'b1;
            state <= DONE;
          end else begin
            timer <= timer_sat;
          end
        end
        DONE: begin
          grant <= '0;
          busy  <= 1'b0;
          ptr   <= ptr_nxt;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
